// File: rtl/sipo_deframer_pkg.sv
// Shared definitions for the serial front-end blocks: FSM state encoding.
package sipo_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT
  } state_e;

endpackage

// File: rtl/sipo_deframer_if.sv
// Serial input / parallel output bundle of the deframer.
// Handshake: a serial bit is transferred on every rising clk edge where
// serial_valid is 1 (no back-pressure); frame_start is only meaningful
// together with serial_valid. On the output side load is a one-cycle
// strobe telling the downstream register to capture parallel_out.
interface sipo_deframer_if #(
  parameter int WIDTH = 4
);
  logic             serial_in;
  logic             serial_valid;
  logic             frame_start;
  logic [WIDTH-1:0] parallel_out;
  logic             load;
  logic             busy;
  logic             frame_err;
  logic             dbg_state;

  modport master (
    output serial_in, serial_valid, frame_start,
    input  parallel_out, load, busy, frame_err, dbg_state
  );

  modport slave (
    input  serial_in, serial_valid, frame_start,
    output parallel_out, load, busy, frame_err, dbg_state
  );
endinterface

// File: rtl/sipo_deframer.sv
// Serial-in parallel-out deframer: assembles framed serial bits into a
// WIDTH-bit word and strobes load for one cycle when a frame completes.
module sipo_deframer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input logic            clk,
  input logic            rst,
  sipo_deframer_if.slave bus
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_e           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_sr, w_sr_nxt;
  logic [WIDTH-1:0] r_po, w_po_nxt;
  logic             r_load, w_load_nxt;
  logic             r_err, w_err_nxt;
  logic [WIDTH-1:0] w_word;

  // Append one bit to a partial word in the configured bit order.
  function automatic logic [WIDTH-1:0] insert_bit(input logic [WIDTH-1:0] word,
                                                  input logic b);
    logic [WIDTH:0] t;
    if (MSB_FIRST != 0) begin
      t = {word, b};
      return t[WIDTH-1:0];
    end else begin
      t = {b, word};
      return t[WIDTH:1];
    end
  endfunction

  // Next-state logic: accept bits, restart on frame_start, complete at WIDTH bits.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sr_nxt    = r_sr;
    w_po_nxt    = r_po;
    w_load_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_word      = '0;
    if (bus.serial_valid) begin
      if (bus.frame_start) begin
        // A start bit inside a frame aborts it; the bit still opens a new one.
        w_err_nxt = (r_state == S_SHIFT);
        w_word    = insert_bit('0, bus.serial_in);
        if (WIDTH == 1) begin
          w_po_nxt    = w_word;
          w_load_nxt  = 1'b1;
          w_sr_nxt    = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_sr_nxt    = w_word;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = S_SHIFT;
        end
      end else if (r_state == S_SHIFT) begin
        w_word = insert_bit(r_sr, bus.serial_in);
        if (r_cnt == LAST_CNT) begin
          w_po_nxt    = w_word;
          w_load_nxt  = 1'b1;
          w_sr_nxt    = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_sr_nxt  = w_word;
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      // Bits without frame_start while idle are dropped silently.
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
      r_po    <= '0;
      r_load  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sr    <= w_sr_nxt;
      r_po    <= w_po_nxt;
      r_load  <= w_load_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.parallel_out = r_po;
  assign bus.load         = r_load;
  assign bus.frame_err    = r_err;
  assign bus.busy         = (r_state == S_SHIFT);
  assign bus.dbg_state    = logic'(r_state);

endmodule

// File: tb/tb_sipo_deframer.sv
// Bench for sipo_deframer: directed scenarios plus a randomized run
// compared against a bit-queue reference model, for both bit orders.
module tb_sipo_deframer;

  localparam int W = 4;

  logic clk;
  logic rst;
  logic s_in, s_v, s_st;

  sipo_deframer_if #(.WIDTH(W)) if_a ();
  sipo_deframer_if #(.WIDTH(W)) if_b ();

  assign if_a.serial_in    = s_in;
  assign if_a.serial_valid = s_v;
  assign if_a.frame_start  = s_st;
  assign if_b.serial_in    = s_in;
  assign if_b.serial_valid = s_v;
  assign if_b.frame_start  = s_st;

  sipo_deframer #(.WIDTH(W), .MSB_FIRST(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  sipo_deframer #(.WIDTH(W), .MSB_FIRST(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // observations of DUT A
  int load_cnt, err_cnt, busy_cnt, load_cyc, err_cyc;
  logic [W-1:0] obs_q[$];
  logic [W-1:0] exp_q[$];

  // reference model: frame is a queue of received bits
  logic         m_bits[$];
  logic         m_busy, m_load, m_err;
  logic [W-1:0] m_po_a, m_po_b;

  task automatic clr();
    load_cnt = 0; err_cnt = 0; busy_cnt = 0; load_cyc = -1; err_cyc = -1;
    obs_q.delete();
  endtask

  task automatic model_update(input logic v, input logic st, input logic b, input logic r);
    if (!r) begin
      m_bits.delete();
      m_busy = 0; m_load = 0; m_err = 0; m_po_a = '0; m_po_b = '0;
    end else begin
      m_load = 0; m_err = 0;
      if (v) begin
        if (st) begin
          if (m_busy) m_err = 1;
          m_bits.delete();
          m_bits.push_back(b);
          m_busy = 1;
        end else if (m_busy) begin
          m_bits.push_back(b);
        end
        if (m_busy && m_bits.size() == W) begin
          m_po_a = '0; m_po_b = '0;
          for (int i = 0; i < W; i++) begin
            m_po_a = m_po_a | (W'(m_bits[i]) << (W - 1 - i));
            m_po_b = m_po_b | (W'(m_bits[i]) << i);
          end
          m_load = 1; m_busy = 0;
          m_bits.delete();
        end
      end
    end
  endtask

  // driver: apply one cycle of stimulus, advance the model, log DUT A events
  task automatic step(input logic v, input logic st, input logic b, input logic r);
    s_v = v; s_st = st; s_in = b; rst = r;
    @(posedge clk);
    #1;
    cyc++;
    model_update(v, st, b, r);
    if (if_a.load === 1'b1) begin
      load_cnt++; load_cyc = cyc; obs_q.push_back(if_a.parallel_out);
    end
    if (if_a.frame_err === 1'b1) begin
      err_cnt++; err_cyc = cyc;
    end
    if (if_a.busy === 1'b1) busy_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if ({if_a.parallel_out, if_a.load, if_a.busy, if_a.frame_err} !== '0) begin
      n_err++;
      $display("FAIL reset_a got po=%b load=%b busy=%b err=%b want all 0",
               if_a.parallel_out, if_a.load, if_a.busy, if_a.frame_err);
    end
    n_vec++;
    if ({if_b.parallel_out, if_b.load, if_b.busy, if_b.frame_err} !== '0) begin
      n_err++;
      $display("FAIL reset_b got po=%b load=%b busy=%b err=%b want all 0",
               if_b.parallel_out, if_b.load, if_b.busy, if_b.frame_err);
    end
  endtask

  task automatic test_basic();
    int last;
    clr();
    step(1, 1, 1, 1); step(1, 0, 0, 1); step(1, 0, 0, 1); step(1, 0, 1, 1);
    last = cyc;
    idle(2);
    n_vec++;
    if (load_cnt != 1) begin n_err++; $display("FAIL basic_loads got %0d want 1", load_cnt); end
    n_vec++;
    if (load_cyc != last) begin n_err++; $display("FAIL basic_load_time got %0d want %0d", load_cyc, last); end
    n_vec++;
    if (if_a.parallel_out !== 4'b1001) begin n_err++; $display("FAIL basic_word got %b want 1001", if_a.parallel_out); end
    n_vec++;
    if (busy_cnt != 3) begin n_err++; $display("FAIL basic_busy got %0d want 3", busy_cnt); end
  endtask

  task automatic test_back_to_back();
    int first;
    clr();
    exp_q.delete();
    exp_q.push_back(4'b1001);
    exp_q.push_back(4'b1101);
    step(1, 1, 1, 1); step(1, 0, 0, 1); step(1, 0, 0, 1); step(1, 0, 1, 1);
    first = load_cyc;
    step(1, 1, 1, 1); step(1, 0, 1, 1); step(1, 0, 0, 1); step(1, 0, 1, 1);
    idle(1);
    n_vec++;
    if (load_cnt != 2) begin n_err++; $display("FAIL b2b_loads got %0d want 2", load_cnt); end
    n_vec++;
    if (load_cyc - first != 4) begin n_err++; $display("FAIL b2b_spacing got %0d want 4", load_cyc - first); end
    n_vec++;
    if (err_cnt != 0) begin n_err++; $display("FAIL b2b_err got %0d want 0", err_cnt); end
    while (exp_q.size() > 0) begin
      logic [W-1:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL b2b_word got %b want %b", o, e); end
    end
  endtask

  task automatic test_gapped();
    logic [3:0] bits;
    int last;
    bits = 4'b1101;
    clr();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i == 0), bits[3-i], 1'b1);
      last = cyc;
      if (i != 3) idle(2);
    end
    idle(1);
    n_vec++;
    if (load_cnt != 1) begin n_err++; $display("FAIL gap_loads got %0d want 1", load_cnt); end
    n_vec++;
    if (load_cyc != last) begin n_err++; $display("FAIL gap_load_time got %0d want %0d", load_cyc, last); end
    n_vec++;
    if (if_a.parallel_out !== 4'b1101) begin n_err++; $display("FAIL gap_word got %b want 1101", if_a.parallel_out); end
  endtask

  task automatic test_abort();
    int third;
    clr();
    step(1, 1, 1, 1); step(1, 0, 1, 1);
    step(1, 1, 0, 1);
    third = cyc;
    step(1, 0, 1, 1); step(1, 0, 1, 1); step(1, 0, 0, 1);
    idle(1);
    n_vec++;
    if (err_cnt != 1) begin n_err++; $display("FAIL abort_errs got %0d want 1", err_cnt); end
    n_vec++;
    if (err_cyc != third) begin n_err++; $display("FAIL abort_err_time got %0d want %0d", err_cyc, third); end
    n_vec++;
    if (load_cnt != 1) begin n_err++; $display("FAIL abort_loads got %0d want 1", load_cnt); end
    n_vec++;
    if (if_a.parallel_out !== 4'b0110) begin n_err++; $display("FAIL abort_word got %b want 0110", if_a.parallel_out); end
    n_vec++;
    if (busy_cnt != 5) begin n_err++; $display("FAIL abort_busy got %0d want 5", busy_cnt); end
  endtask

  task automatic test_reset_mid();
    clr();
    step(1, 1, 1, 1); step(1, 0, 0, 1);
    step(0, 0, 0, 0);
    n_vec++;
    if ({if_a.parallel_out, if_a.load, if_a.busy, if_a.frame_err} !== '0) begin
      n_err++;
      $display("FAIL rstmid_outputs got po=%b load=%b busy=%b err=%b want all 0",
               if_a.parallel_out, if_a.load, if_a.busy, if_a.frame_err);
    end
    step(1, 1, 0, 1); step(1, 0, 0, 1); step(1, 0, 1, 1); step(1, 0, 1, 1);
    idle(1);
    n_vec++;
    if (load_cnt != 1 || err_cnt != 0) begin
      n_err++; $display("FAIL rstmid_pulses got load=%0d err=%0d want 1 and 0", load_cnt, err_cnt);
    end
    n_vec++;
    if (if_a.parallel_out !== 4'b0011) begin n_err++; $display("FAIL rstmid_word got %b want 0011", if_a.parallel_out); end
  endtask

  task automatic test_lsb_first_and_stray();
    step(1, 1, 1, 1); step(1, 0, 0, 1); step(1, 0, 0, 1); step(1, 0, 0, 1);
    n_vec++;
    if (if_b.parallel_out !== 4'b0001 || if_b.load !== 1'b1) begin
      n_err++; $display("FAIL lsb_word got %b load=%b want 0001 load=1", if_b.parallel_out, if_b.load);
    end
    n_vec++;
    if (if_a.parallel_out !== 4'b1000) begin n_err++; $display("FAIL msb_word got %b want 1000", if_a.parallel_out); end
    idle(1);
    clr();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
      n_vec++;
      if (if_b.busy !== 1'b0 || if_b.load !== 1'b0 || if_b.frame_err !== 1'b0) begin
        n_err++; $display("FAIL stray_b got busy=%b load=%b err=%b want 0 0 0", if_b.busy, if_b.load, if_b.frame_err);
      end
    end
    n_vec++;
    if (busy_cnt != 0 || load_cnt != 0 || err_cnt != 0) begin
      n_err++; $display("FAIL stray_a got busy=%0d load=%0d err=%0d want 0 0 0", busy_cnt, load_cnt, err_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic v, st, b, r;
      v  = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 5) == 0);
      b  = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 99) != 0);
      step(v, st, b, r);
      n_vec++;
      if (if_a.parallel_out !== m_po_a || if_a.load !== m_load ||
          if_a.frame_err !== m_err || if_a.busy !== m_busy) begin
        n_err++;
        $display("FAIL rand_a cyc=%0d got po=%b load=%b err=%b busy=%b want po=%b load=%b err=%b busy=%b",
                 cyc, if_a.parallel_out, if_a.load, if_a.frame_err, if_a.busy,
                 m_po_a, m_load, m_err, m_busy);
      end
      n_vec++;
      if (if_b.parallel_out !== m_po_b || if_b.load !== m_load ||
          if_b.frame_err !== m_err || if_b.busy !== m_busy) begin
        n_err++;
        $display("FAIL rand_b cyc=%0d got po=%b load=%b err=%b busy=%b want po=%b load=%b err=%b busy=%b",
                 cyc, if_b.parallel_out, if_b.load, if_b.frame_err, if_b.busy,
                 m_po_b, m_load, m_err, m_busy);
      end
    end
  endtask

  initial begin
    rst = 1'b0; s_v = 1'b0; s_st = 1'b0; s_in = 1'b0;
    m_busy = 0; m_load = 0; m_err = 0; m_po_a = '0; m_po_b = '0;
    clr();
    test_reset();
    test_basic();
    test_back_to_back();
    test_gapped();
    test_abort();
    test_reset_mid();
    test_lsb_first_and_stray();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
